// File: rtl/uart_rx_fifo_pkg.sv
// uart_defs: receiver state encodings and frame constants shared by the UART RX slice
package uart_defs;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  localparam int CLK_DIV_DEF = 16;
  localparam int FRAME_W = 8;
endpackage

// File: rtl/uart_rx_fifo_fifo.sv
// rx_fifo: counter-based byte FIFO with show-ahead head; COUNT keeps full and empty distinct
module rx_fifo #(
  parameter int pSize = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WE,
  input  logic [7:0]       DIN,
  input  logic             RE,
  output logic [7:0]       OUT,
  output logic             EMPTY,
  output logic             FULL,
  output logic [pSize:0]   COUNT
);
  localparam int DEPTH = 1 << pSize;
  logic [7:0] mem [DEPTH];
  logic [pSize-1:0] wr, rd;
  logic pop, push;
  assign pop = RE && !EMPTY;
  // a write while full is only taken when the same edge frees a slot
  assign push = WE && (!FULL || pop);
  assign EMPTY = COUNT == '0;
  assign FULL = COUNT[pSize];
  assign OUT = EMPTY ? 8'h00 : mem[rd];
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr <= '0;
      rd <= '0;
      COUNT <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      COUNT <= COUNT + {{pSize{1'b0}}, push} - {{pSize{1'b0}}, pop};
    end
  end
  always_ff @(posedge CLK) begin
    if (push) mem[wr] <= DIN;
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead receive FIFO, with framing-error and overrun pulses
module uart_rx_fifo
  import uart_defs::*;
#(
  parameter int pClkDiv = CLK_DIV_DEF,
  parameter int pSize = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             RX,
  input  logic             RE,
  output logic [7:0]       OUT,
  output logic             EMPTY,
  output logic             FULL,
  output logic [pSize:0]   COUNT,
  output logic             FERR,
  output logic             OVR
);
  localparam int CW = $clog2(pClkDiv);
  localparam logic [CW-1:0] HALF = CW'(pClkDiv / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(pClkDiv - 1);
  localparam int IW = $clog2(FRAME_W);
  rx_state_t state, state_d;
  logic [1:0] sync;
  logic rxs;
  logic [CW-1:0] cnt, cnt_d;
  logic [IW-1:0] idx, idx_d;
  logic [FRAME_W-1:0] sh, sh_d;
  logic push, ferr_d;
  assign rxs = sync[1];
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      FERR <= 1'b0;
      OVR <= 1'b0;
    end else begin
      sync <= {sync[0], RX};
      state <= state_d;
      cnt <= cnt_d;
      idx <= idx_d;
      sh <= sh_d;
      FERR <= ferr_d;
      OVR <= push && FULL && !RE;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt + 1'b1;
    idx_d = idx;
    sh_d = sh;
    push = 1'b0;
    ferr_d = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: if (cnt == HALF) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rxs ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_d = '0;
        sh_d = {rxs, sh[FRAME_W-1:1]};
        idx_d = idx + 1'b1;
        if (idx == IW'(FRAME_W - 1)) state_d = STOP;
      end
      STOP: if (cnt == LAST) begin
        cnt_d = '0;
        push = rxs;
        ferr_d = !rxs;
        state_d = rxs ? IDLE : BREAK;
      end
      BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  rx_fifo #(.pSize(pSize)) u_fifo (
    .CLK(CLK),
    .RST_N(RST_N),
    .WE(push),
    .DIN(sh),
    .RE(RE),
    .OUT(OUT),
    .EMPTY(EMPTY),
    .FULL(FULL),
    .COUNT(COUNT)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized frames checked against a queue model of the receive FIFO
module tb_uart_rx_fifo;
  localparam int DIV = 16;
  localparam int SZ = 2;
  localparam int DEPTH = 4;
  logic CLK = 1'b0, RST_N = 1'b0, RX = 1'b1, RE = 1'b0;
  logic [7:0] OUT;
  logic EMPTY, FULL, FERR, OVR;
  logic [SZ:0] COUNT;
  int total = 0, passed = 0;
  int ferr_n = 0, ovr_n = 0, both_n = 0, ferr_e = 0, ovr_e = 0;
  logic [7:0] q[$];

  uart_rx_fifo #(.pClkDiv(DIV), .pSize(SZ)) dut (
    .CLK(CLK), .RST_N(RST_N), .RX(RX), .RE(RE), .OUT(OUT), .EMPTY(EMPTY),
    .FULL(FULL), .COUNT(COUNT), .FERR(FERR), .OVR(OVR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (FERR) ferr_n++;
    if (OVR) ovr_n++;
    if (FERR && OVR) both_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive(input logic v, input int n);
    RX = v;
    idle(n);
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int hold);
    drive(1'b0, DIV);
    for (int i = 0; i < 8; i++) drive(b[i], DIV);
    drive(stop, stop ? DIV : hold);
    RX = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input logic stop, input int hold);
    send(b, stop, hold);
    if (!stop) ferr_e++;
    else if (q.size() < DEPTH) q.push_back(b);
    else ovr_e++;
    idle(6);
  endtask

  task automatic state_chk(input string tag);
    chk({tag, " count"}, 32'(COUNT), 32'(q.size()));
    chk({tag, " empty"}, 32'(EMPTY), 32'(q.size() == 0));
    chk({tag, " full"}, 32'(FULL), 32'(q.size() == DEPTH));
  endtask

  task automatic pop_chk(input string tag);
    chk({tag, " out"}, 32'(OUT), q.size() != 0 ? 32'(q[0]) : 32'h0);
    RE = 1'b1;
    idle(1);
    RE = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  initial begin
    idle(3);
    chk("reset empty", 32'(EMPTY), 32'd1);
    chk("reset full", 32'(FULL), 32'd0);
    chk("reset count", 32'(COUNT), 32'd0);
    chk("reset out", 32'(OUT), 32'h00);
    chk("reset ferr", 32'(FERR), 32'd0);
    chk("reset ovr", 32'(OVR), 32'd0);
    RST_N = 1'b1;
    idle(4);
    fork
      send(8'hA5, 1'b1, DIV);
      begin
        idle(153);
        chk("t1 not yet", 32'(EMPTY), 32'd1);
        idle(3);
        chk("t1 empty", 32'(EMPTY), 32'd0);
        chk("t1 out", 32'(OUT), 32'hA5);
        chk("t1 count", 32'(COUNT), 32'd1);
      end
    join
    q.push_back(8'hA5);
    idle(6);
    pop_chk("t1 pop");
    state_chk("t1 drained");
    chk("t1 out empty", 32'(OUT), 32'h00);
    frame(8'h3C, 1'b0, 40);
    idle(20);
    chk("t2 ferr", 32'(ferr_n), 32'(ferr_e));
    chk("t2 ovr", 32'(ovr_n), 32'(ovr_e));
    state_chk("t2 discard");
    frame(8'h55, 1'b1, DIV);
    state_chk("t2 after");
    pop_chk("t2 pop");
    drive(1'b0, 4);
    drive(1'b1, 30);
    chk("t3 ferr", 32'(ferr_n), 32'(ferr_e));
    state_chk("t3 glitch");
    frame(8'h81, 1'b1, DIV);
    pop_chk("t3 pop");
    for (int b = 1; b <= 5; b++) begin
      frame(8'(b), 1'b1, DIV);
      if (b == 4) state_chk("t4 full");
    end
    chk("t4 ovr", 32'(ovr_n), 32'(ovr_e));
    state_chk("t4 after ovr");
    repeat (4) pop_chk("t4 drain");
    state_chk("t4 drained");
    for (int b = 1; b <= 4; b++) frame(8'(b), 1'b1, DIV);
    fork
      send(8'h06, 1'b1, DIV);
      begin
        idle(154);
        RE = 1'b1;
        idle(1);
        RE = 1'b0;
      end
    join
    void'(q.pop_front());
    q.push_back(8'h06);
    idle(6);
    state_chk("t5 simul");
    chk("t5 ovr", 32'(ovr_n), 32'(ovr_e));
    repeat (4) pop_chk("t5 drain");
    state_chk("t5 drained");
    frame(8'h11, 1'b1, DIV);
    frame(8'h22, 1'b1, DIV);
    drive(1'b0, DIV);
    drive(1'b1, DIV);
    drive(1'b0, DIV);
    drive(1'b1, 7);
    #2 RST_N = 1'b0;
    #1;
    chk("t6 empty", 32'(EMPTY), 32'd1);
    chk("t6 count", 32'(COUNT), 32'd0);
    chk("t6 out", 32'(OUT), 32'h00);
    chk("t6 full", 32'(FULL), 32'd0);
    q.delete();
    RX = 1'b1;
    idle(3);
    RST_N = 1'b1;
    idle(5);
    frame(8'hC3, 1'b1, DIV);
    pop_chk("t6 pop");
    state_chk("t6 drained");
    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      logic stop;
      b = 8'($urandom_range(0, 255));
      stop = $urandom_range(0, 5) != 0;
      frame(b, stop, DIV + int'($urandom_range(0, 30)));
      state_chk("rnd state");
      repeat ($urandom_range(0, 2)) pop_chk("rnd pop");
    end
    while (q.size() != 0) pop_chk("rnd drain");
    state_chk("rnd end");
    chk("rnd ferr", 32'(ferr_n), 32'(ferr_e));
    chk("rnd ovr", 32'(ovr_n), 32'(ovr_e));
    chk("pulse overlap", 32'(both_n), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side counterpart of the byte TX FIFO. It deserialises 8N1 UART frames from the serial RX line and pushes each good byte into an internal receive FIFO, which the consumer drains with a show-ahead read handshake. The block sits between the board RX pin and the command/data consumer logic. It also reports framing errors and overruns.

Parameters:
pClkDiv, 16, CLK cycles per bit period (integer ≥ 4, even; e.g. 104 for 12 MHz / 115200).
pSize, 4, log2 of FIFO depth; depth = 1 << pSize entries, all usable.

Ports:
CLK  input  1  system clock; all logic on posedge.
RST_N  input  1  asynchronous, active-low reset.
RX  input  1  asynchronous serial line, idle high.
RE  input  1  read enable; pops the head entry when !EMPTY.
OUT  output  8  head byte (show-ahead); 8'h00 when EMPTY.
EMPTY  output  1  FIFO holds no entries.
FULL  output  1  FIFO holds 1 << pSize entries.
COUNT  output  pSize+1  number of stored entries.
FERR  output  1  one-cycle pulse: frame had stop bit = 0.
OVR  output  1  one-cycle pulse: good byte dropped because FIFO full.

Behaviour:
- Reset (RST_N low, async): state IDLE, sync flops = 1, pointers/count = 0; EMPTY=1, FULL=0, COUNT=0, OUT=8'h00, FERR=0, OVR=0. Reset mid-frame abandons the frame.
- RX passes through a 2-flop synchroniser (reset value 1); all sampling uses the synchronised value rxs.
- Bit counter: cnt counts CLK cycles within a bit; bit index 0..7.
- FSM:
  - IDLE: rxs==0 -> START, cnt=0.
  - START: at cnt == pClkDiv/2-1, sample. If rxs==1, the start was a glitch: go to IDLE with no flags. Otherwise go to DATA, index=0, cnt=0.
  - DATA: at cnt == pClkDiv-1, sample into shift register LSB-first. After index 7 -> STOP.
  - STOP: at cnt == pClkDiv-1, sample the stop bit.
    - rxs==1: push byte (or OVR) and go to IDLE.
    - rxs==0: FERR pulse, byte discarded, go to BREAK.
  - BREAK: wait for rxs==1, then IDLE. Holding the line low does not re-trigger.
- Push happens on the stop-sample edge. EMPTY/COUNT/OUT reflect it on the following cycle.
- Latency: a valid byte appears at OUT 2 + pClkDiv/2 + 9*pClkDiv cycles (±1) after the RX falling edge.
- FIFO:
  - Write pointer wr, read pointer rd, each pSize bits, wrapping modulo depth. COUNT is kept separately, so full vs empty is unambiguous.
  - Pop: RE && !EMPTY advances rd at the edge. RE while EMPTY is ignored.
  - Push when FULL with no pop in the same cycle: byte dropped, OVR=1 for one cycle, FIFO untouched.
  - Push with a pop in the same cycle is always accepted (including when FULL). COUNT is unchanged.
  - OUT = EMPTY ? 8'h00 : mem[rd], combinational from the registered pointer and memory.
- FERR and OVR are registered, high for exactly one cycle, and never both in the same cycle.

Decomposition:
- Shared package/include uart_defs: FSM state encodings (IDLE, START, DATA, STOP, BREAK), default divider constant, frame width (8).
- One natural sub-module: rx_fifo, a synchronous counter-based FIFO with parameter pSize and ports CLK, RST_N, WE, DIN, RE, OUT, EMPTY, FULL, COUNT.
- uart_rx_fifo holds the synchroniser, FSM, shift register, and OVR/FERR generation.

Test Plan (pClkDiv=16, pSize=2, i.e. depth 4):
1. Send 0xA5 (8N1). At the expected latency, EMPTY=0, OUT=0xA5, COUNT=1. Pulse RE one cycle: next cycle EMPTY=1, OUT=0x00, COUNT=0.
2. Send 0x3C with stop bit 0, RX held low 40 cycles, then high. Expect one FERR pulse, COUNT stays 0, no OVR. Then send 0x55: OUT=0x55, COUNT=1.
3. RX low for 4 cycles only (less than half a bit), then high. Expect no push, no FERR, and the FSM back in IDLE. A following 0x81 is received correctly.
4. Send 0x01..0x05 with no reads. FULL=1 after the 4th byte. The 5th byte gives one OVR pulse. Draining yields 0x01, 0x02, 0x03, 0x04, then EMPTY=1.
5. With FULL, assert RE in the same cycle as the stop-sample push of 0x06. Expect COUNT=4, FULL=1, no OVR. Drain order is 0x02..0x04, 0x06, and the pointers have wrapped.
6. Assert RST_N low mid-DATA of a frame with 2 bytes queued. Immediately: EMPTY=1, COUNT=0, OUT=0x00, FULL=0. After release, with RX idle high, send 0xC3: it is received correctly.
